program_loader: RTL
===================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL: clk  input  1  system clock; all state updates on its rising edge.
REQ-002 SHALL: clr  input  1  reset, asynchronous, active-high.
REQ-003 SHALL: start  input  1  one-cycle request to begin loading at address 0.
REQ-004 SHALL: in_valid  input  1  instruction word available on in_word.
REQ-005 SHALL: in_word  input  8  instruction word, {opcode[7:5], address field[4:0]}.
REQ-006 SHALL: in_ready  output  1  loader accepts in_word this cycle.
REQ-007 SHALL: mem_addr  output  5  program memory write address.
REQ-008 SHALL: mem_data  output  8  program memory write data.
REQ-009 SHALL: mem_wr  output  1  program memory write strobe, one cycle per word.
REQ-010 SHALL: busy  output  1  high in LOAD and WRITE states.
REQ-011 SHALL: cpu_run  output  1  releases the CPU sequence counter; high only in DONE.
REQ-012 SHALL: err  output  1  program exceeded 32 words without a HLT word.
REQ-013 SHALL: checksum  output  8  running modulo-256 sum of the words written.

Function
REQ-014 SHALL: implement FSM states IDLE, LOAD, WRITE, DONE, ERR.
REQ-015 SHALL: in IDLE, DONE and ERR, a start pulse clears the address counter and checksum, clears err, deasserts cpu_run, and moves to LOAD on the next edge.
REQ-016 SHALL: in LOAD, hold in_ready=1; on in_valid&in_ready, latch in_word and move to WRITE.
REQ-017 SHALL: in WRITE, drive mem_wr=1, mem_addr=counter and mem_data=latched word for exactly one cycle; in_ready=0.
REQ-018 SHALL: from WRITE, if latched opcode==3'd4 (HLT), move to DONE.
REQ-019 SHALL: from WRITE, else if counter==31, move to ERR.
REQ-020 SHALL: from WRITE, otherwise increment counter and return to LOAD.
REQ-021 SHALL: sustain a throughput of one word per two cycles; the first mem_wr occurs one cycle after acceptance.
REQ-022 SHALL: ignore start while in LOAD or WRITE.
REQ-023 SHALL: ignore in_valid outside LOAD.
REQ-024 SHALL: hold mem_addr and mem_data stable and mem_wr=0 outside WRITE.
REQ-025 SHALL: stay in DONE, with cpu_run=1, until start or clr.
REQ-026 SHALL: stay in ERR, with err=1 and cpu_run=0, until start or clr.
REQ-027 SHALL: never let the counter wrap past 31 (no write to address 0 after 31).

Reset
REQ-028 SHALL: on clr, immediately and without waiting for clk, enter IDLE.
REQ-029 SHALL: on clr, force counter=0, mem_addr=0, mem_data=0, mem_wr=0, in_ready=0, busy=0, cpu_run=0, err=0 and checksum=0.
REQ-030 SHALL: if clr asserts during WRITE, drop mem_wr asynchronously; the interrupted word is considered not written.

Configuration
REQ-031 SHALL: when LOADER_CHECKSUM_EN is defined, add each written word into checksum (mod 256) on the edge ending WRITE.
REQ-032 SHALL: when LOADER_CHECKSUM_EN is undefined, hold checksum constant 8'h00 and infer no adder; the port remains present.

Verification
REQ-033 SHALL: clr, start, words 8'h03, 8'h24, 8'h80 -> writes at addresses 0/1/2; cpu_run=1 two cycles after the last acceptance; checksum=8'hA7 (8'h00 without the macro).
REQ-034 SHALL: 32 words of opcode 3'd1 with no HLT -> 32 writes at addresses 0..31, then err=1, cpu_run=0, no 33rd write.
REQ-035 SHALL: in_valid held high continuously -> in_ready toggles 1,0,1,0; exactly one mem_wr per accepted word.
REQ-036 SHALL: clr pulsed mid-WRITE at word 5 -> mem_wr falls before the next edge; all outputs return to reset values; a following start loads from address 0.
REQ-037 SHALL: start pulsed during LOAD -> counter unchanged, loading continues; start in DONE -> cpu_run=0 and reload from address 0.

Source files
------------

// File: rtl/program_loader.sv
// Loads a program word-by-word into CPU memory, then releases the CPU.
// Optional LOADER_CHECKSUM_EN adds a running mod-256 sum of the written words.
module program_loader (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_word,
  output logic       in_ready,
  output logic [4:0] mem_addr,
  output logic [7:0] mem_data,
  output logic       mem_wr,
  output logic       busy,
  output logic       cpu_run,
  output logic       err,
  output logic [7:0] checksum
);

  localparam logic [2:0] OP_HLT   = 3'd4;
  localparam logic [4:0] LAST_ADR = 5'd31;

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, ERR} state_t;

  state_t     state, state_nxt;
  logic [4:0] cnt;
  logic       accept;
  logic       restart;
  logic       is_hlt;

  assign accept  = (state == LOAD) && in_valid;
  assign restart = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  // mem_data holds the latched word throughout WRITE, so decode HLT from it
  assign is_hlt  = (mem_data[7:5] == OP_HLT);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mem_wr    = 1'b0;
    busy      = 1'b0;
    cpu_run   = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = LOAD;
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_nxt = WRITE;
      end
      WRITE: begin
        mem_wr = 1'b1;
        busy   = 1'b1;
        if (is_hlt)                state_nxt = DONE;
        else if (cnt == LAST_ADR)  state_nxt = ERR;
        else                       state_nxt = LOAD;
      end
      DONE: begin
        cpu_run = 1'b1;
        if (start) state_nxt = LOAD;
      end
      ERR: begin
        err = 1'b1;
        if (start) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address/data are captured at acceptance so they stay frozen outside WRITE
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt      <= '0;
      mem_addr <= '0;
      mem_data <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (accept) begin
      mem_addr <= cnt;
      mem_data <= in_word;
    end else if ((state == WRITE) && !is_hlt && (cnt != LAST_ADR)) begin
      cnt <= cnt + 5'd1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum;

  always_ff @(posedge clk or posedge clr) begin
    if (clr)                 sum <= '0;
    else if (restart)        sum <= '0;
    else if (state == WRITE) sum <= sum + mem_data;
  end

  assign checksum = sum;
`else
  assign checksum = 8'h00;
`endif

endmodule
